// File: rtl/cpu_step_controller_if.sv
// ---------------------------------------------------------------------------
// cpu_step_controller_if
//   Bundles the step controller's board-side inputs (debounced step button,
//   run switch, breakpoint setup, processor PC) and its outputs (step strobe
//   and status for the display mux).
//
//   master : the surrounding board logic / testbench; drives the inputs
//   slave  : the step controller itself
//
//   Signals
//     step_btn    debounced step button level
//     run_sw      run switch level, 1 = request free-run
//     bp_en       breakpoint compare enable
//     bp_addr     breakpoint PC value (PC_W)
//     pc          current processor PC (PC_W)
//     step_pulse  one-cycle strobe, one instruction per strobe
//     running     1 while free-running
//     halted      1 while stopped on a breakpoint
//     bp_hit      1 while stopped on a breakpoint
//     step_count  number of strobes issued since reset (CNT_W, wraps)
// ---------------------------------------------------------------------------
interface cpu_step_controller_if #(
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
);
    logic             step_btn;
    logic             run_sw;
    logic             bp_en;
    logic [PC_W-1:0]  bp_addr;
    logic [PC_W-1:0]  pc;
    logic             step_pulse;
    logic             running;
    logic             halted;
    logic             bp_hit;
    logic [CNT_W-1:0] step_count;

    modport master (
        output step_btn, run_sw, bp_en, bp_addr, pc,
        input  step_pulse, running, halted, bp_hit, step_count
    );

    modport slave (
        input  step_btn, run_sw, bp_en, bp_addr, pc,
        output step_pulse, running, halted, bp_hit, step_count
    );
endinterface

// File: rtl/cpu_step_controller.sv
// ---------------------------------------------------------------------------
// cpu_step_controller
//   Turns the debounced step button and the run switch into one-cycle step
//   strobes for the single-cycle processor. Modes: manual single-step (IDLE),
//   free-run at one step every RATE_DIV cycles (RUN), and stop on a PC match
//   (BP_HALT). Every output is a register.
//
//   Ports
//     clk     in  system clock, rising edge
//     reset   in  asynchronous active-low reset
//     bus     slave modport of cpu_step_controller_if (step_btn, run_sw,
//             bp_en, bp_addr, pc in; step_pulse, running, halted, bp_hit,
//             step_count out)
// ---------------------------------------------------------------------------
module cpu_step_controller #(
    parameter int RATE_DIV = 25_000_000,
    parameter int PC_W     = 32,
    parameter int CNT_W    = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    cpu_step_controller_if.slave  bus
);

    localparam int               DIV_W    = (RATE_DIV > 2) ? $clog2(RATE_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(RATE_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_BP_HALT = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               btn_q, run_q;
    logic               pulse_q, pulse_d;
    logic               running_q, halted_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic               btn_rise, run_rise, at_terminal, bp_match;
    logic [PC_W-1:0]    pc_w, bp_w;

    assign pc_w        = bus.pc;
    assign bp_w        = bus.bp_addr;
    assign btn_rise    = bus.step_btn & ~btn_q;
    assign run_rise    = bus.run_sw & ~run_q;
    assign at_terminal = (div_q == DIV_LAST);
    // Full-width compare, no masking of low PC bits.
    assign bp_match    = bus.bp_en & (pc_w == bp_w);

    // ---- decide: next state, divider and step strobe ----
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        pulse_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                // Run request wins over a button edge in the same cycle.
                if (run_rise) begin
                    state_d = ST_RUN;
                    div_d   = '0;
                end else if (btn_rise) begin
                    pulse_d = 1'b1;
                end
            end
            ST_RUN: begin
                if (!bus.run_sw) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                end else if (at_terminal) begin
                    div_d = '0;
                    if (bp_match) begin
                        state_d = ST_BP_HALT;
                    end else begin
                        pulse_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            ST_BP_HALT: begin
                // The resume strobe moves pc off the breakpoint before the
                // next compare, so execution continues past it.
                if (!bus.run_sw) begin
                    state_d = ST_IDLE;
                    div_d   = '0;
                end else if (btn_rise) begin
                    pulse_d = 1'b1;
                    state_d = ST_RUN;
                    div_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
                div_d   = '0;
            end
        endcase
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, pulse_d};
    end

    // ---- register: state plus registered outputs ----
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            div_q     <= '0;
            btn_q     <= 1'b0;
            run_q     <= 1'b0;
            pulse_q   <= 1'b0;
            running_q <= 1'b0;
            halted_q  <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            btn_q     <= bus.step_btn;
            run_q     <= bus.run_sw;
            pulse_q   <= pulse_d;
            running_q <= (state_d == ST_RUN);
            halted_q  <= (state_d == ST_BP_HALT);
            cnt_q     <= cnt_d;
        end
    end

    assign bus.step_pulse = pulse_q;
    assign bus.running    = running_q;
    assign bus.halted     = halted_q;
    assign bus.bp_hit     = halted_q;
    assign bus.step_count = cnt_q;

endmodule

// File: tb/tb_cpu_step_controller.sv
module tb_cpu_step_controller;

    localparam int RD     = 4;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    logic clk;
    logic reset;

    cpu_step_controller_if #(.PC_W(32), .CNT_W(16)) bus();
    cpu_step_controller_if #(.PC_W(32), .CNT_W(4))  bus4();

    assign bus4.step_btn = bus.step_btn;
    assign bus4.run_sw   = bus.run_sw;
    assign bus4.bp_en    = bus.bp_en;
    assign bus4.bp_addr  = bus.bp_addr;
    assign bus4.pc       = bus.pc;

    cpu_step_controller #(.RATE_DIV(RD), .PC_W(32), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    // Narrow-counter copy so counter wrap is reachable in few cycles.
    cpu_step_controller #(.RATE_DIV(RD), .PC_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: mode plus cycles elapsed since the last RUN entry.
    int          m_mode;
    int          m_ticks;
    bit          m_pb, m_pr;
    bit          e_pulse;
    int unsigned e_cnt;

    task automatic model_reset();
        m_mode = M_IDLE; m_ticks = 0; m_pb = 0; m_pr = 0; e_pulse = 0; e_cnt = 0;
    endtask

    task automatic model_step();
        bit br, rr;
        br = bus.step_btn && !m_pb;
        rr = bus.run_sw && !m_pr;
        e_pulse = 0;
        if (m_mode == M_IDLE) begin
            if (rr) begin m_mode = M_RUN; m_ticks = 0; end
            else if (br) e_pulse = 1;
        end else if (!bus.run_sw) begin
            m_mode = M_IDLE;
        end else if (m_mode == M_RUN) begin
            m_ticks++;
            if (m_ticks % RD == 0) begin
                if (bus.bp_en && bus.pc == bus.bp_addr) m_mode = M_HALT;
                else e_pulse = 1;
            end
        end else if (br) begin
            e_pulse = 1; m_mode = M_RUN; m_ticks = 0;
        end
        if (e_pulse) e_cnt = (e_cnt + 1) & 32'hFFFF;
        m_pb = bus.step_btn;
        m_pr = bus.run_sw;
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        bus.step_btn = 0; bus.run_sw = 0; bus.bp_en = 0;
        bus.bp_addr = 32'h0; bus.pc = 32'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.step_pulse !== 1'b0) begin errors++; $display("FAIL rst_pulse got %b exp 0", bus.step_pulse); end
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL rst_running got %b exp 0", bus.running); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL rst_halted got %b exp 0", bus.halted); end
        checks++; if (bus.bp_hit !== 1'b0) begin errors++; $display("FAIL rst_bp_hit got %b exp 0", bus.bp_hit); end
        checks++; if (bus.step_count !== 16'h0) begin errors++; $display("FAIL rst_count got %h exp 0000", bus.step_count); end
        reset = 1'b1;
    endtask

    task automatic test_single_step();
        int pulses = 0;
        int first_at = -1;
        bus.step_btn = 1;
        for (int k = 1; k <= 10; k++) begin
            cycle();
            checks++; if (bus.step_pulse !== e_pulse) begin errors++; $display("FAIL step_pulse_k%0d got %b exp %b", k, bus.step_pulse, e_pulse); end
            if (bus.step_pulse === 1'b1) begin
                pulses++;
                if (first_at < 0) first_at = k;
            end
        end
        bus.step_btn = 0;
        cycle();
        checks++; if (pulses != 1) begin errors++; $display("FAIL step_pulse_total got %0d exp 1", pulses); end
        checks++; if (first_at != 1) begin errors++; $display("FAIL step_latency got %0d exp 1", first_at); end
        checks++; if (bus.step_count !== 16'd1) begin errors++; $display("FAIL step_count got %h exp 0001", bus.step_count); end
    endtask

    task automatic test_free_run();
        int unsigned start = e_cnt;
        bit exp_p;
        bus.bp_en = 0;
        bus.run_sw = 1;
        for (int k = 1; k <= 17; k++) begin
            cycle();
            exp_p = (k > 1) && ((k - 1) % RD == 0);
            checks++; if (bus.step_pulse !== exp_p) begin errors++; $display("FAIL run_pulse_k%0d got %b exp %b", k, bus.step_pulse, exp_p); end
            checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL run_running_k%0d got %b exp 1", k, bus.running); end
        end
        checks++; if (bus.step_count !== 16'((start + 4) & 32'hFFFF)) begin errors++; $display("FAIL run_count got %h exp %h", bus.step_count, 16'(start + 4)); end
        bus.run_sw = 0;
        cycle();
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL run_exit got %b exp 0", bus.running); end
    endtask

    task automatic test_breakpoint();
        bus.bp_en = 1; bus.bp_addr = 32'h10; bus.pc = 32'h10;
        bus.run_sw = 1;
        for (int k = 1; k <= 5; k++) begin
            cycle();
            checks++; if (bus.step_pulse !== 1'b0) begin errors++; $display("FAIL bp_nopulse_k%0d got %b exp 0", k, bus.step_pulse); end
        end
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL bp_halted got %b exp 1", bus.halted); end
        checks++; if (bus.bp_hit !== 1'b1) begin errors++; $display("FAIL bp_hit got %b exp 1", bus.bp_hit); end
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL bp_running got %b exp 0", bus.running); end
        repeat (2) cycle();
        checks++; if (bus.halted !== 1'b1) begin errors++; $display("FAIL bp_stays got %b exp 1", bus.halted); end
        bus.step_btn = 1;
        cycle();
        checks++; if (bus.step_pulse !== 1'b1) begin errors++; $display("FAIL bp_resume_pulse got %b exp 1", bus.step_pulse); end
        checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL bp_resume_running got %b exp 1", bus.running); end
        checks++; if (bus.halted !== 1'b0) begin errors++; $display("FAIL bp_resume_halted got %b exp 0", bus.halted); end
        bus.step_btn = 0; bus.pc = 32'h14;
        for (int k = 1; k <= RD; k++) begin
            cycle();
            checks++; if (bus.step_pulse !== (k == RD)) begin errors++; $display("FAIL bp_next_k%0d got %b exp %b", k, bus.step_pulse, (k == RD)); end
        end
        bus.run_sw = 0; bus.bp_en = 0;
        cycle();
        checks++; if (bus.running !== 1'b0 || bus.halted !== 1'b0) begin errors++; $display("FAIL bp_exit got run=%b halt=%b exp 0 0", bus.running, bus.halted); end
    endtask

    task automatic test_simultaneous();
        int unsigned start = e_cnt;
        bus.run_sw = 1; bus.step_btn = 1;
        cycle();
        checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL sim_enter got %b exp 1", bus.running); end
        checks++; if (bus.step_pulse !== 1'b0) begin errors++; $display("FAIL sim_nopulse got %b exp 0", bus.step_pulse); end
        bus.step_btn = 0;
        repeat (RD - 1) cycle();
        bus.run_sw = 0;
        cycle();
        checks++; if (bus.step_pulse !== 1'b0) begin errors++; $display("FAIL sim_tc_pulse got %b exp 0", bus.step_pulse); end
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL sim_tc_idle got %b exp 0", bus.running); end
        checks++; if (bus.step_count !== 16'(start)) begin errors++; $display("FAIL sim_count got %h exp %h", bus.step_count, 16'(start)); end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 20 && ((e_cnt & 15) != 15); i++) begin
            bus.step_btn = 1; cycle();
            bus.step_btn = 0; cycle();
        end
        checks++; if (bus4.step_count !== 4'hF) begin errors++; $display("FAIL wrap_pre got %h exp f", bus4.step_count); end
        bus.step_btn = 1;
        cycle();
        checks++; if (bus4.step_pulse !== 1'b1) begin errors++; $display("FAIL wrap_pulse got %b exp 1", bus4.step_pulse); end
        checks++; if (bus4.step_count !== 4'h0) begin errors++; $display("FAIL wrap_count got %h exp 0", bus4.step_count); end
        checks++; if (bus.step_count !== 16'(e_cnt)) begin errors++; $display("FAIL wrap_main got %h exp %h", bus.step_count, 16'(e_cnt)); end
        bus.step_btn = 0;
        cycle();
    endtask

    task automatic test_async_reset();
        int seen = 0;
        bus.bp_en = 0; bus.run_sw = 1;
        for (int k = 1; k <= 10 && seen == 0; k++) begin
            cycle();
            if (bus.step_pulse === 1'b1) seen = k;
        end
        checks++; if (seen != RD + 1) begin errors++; $display("FAIL ar_first_pulse got %0d exp %0d", seen, RD + 1); end
        #2 reset = 1'b0;
        #1;
        checks++; if (bus.step_pulse !== 1'b0) begin errors++; $display("FAIL ar_pulse got %b exp 0", bus.step_pulse); end
        checks++; if (bus.running !== 1'b0) begin errors++; $display("FAIL ar_running got %b exp 0", bus.running); end
        checks++; if (bus.halted !== 1'b0 || bus.bp_hit !== 1'b0) begin errors++; $display("FAIL ar_halt got %b %b exp 0 0", bus.halted, bus.bp_hit); end
        checks++; if (bus.step_count !== 16'h0) begin errors++; $display("FAIL ar_count got %h exp 0000", bus.step_count); end
        model_reset();
        reset = 1'b1;
        cycle();
        checks++; if (bus.running !== 1'b1) begin errors++; $display("FAIL ar_rerun got %b exp 1", bus.running); end
        for (int k = 1; k <= RD; k++) begin
            cycle();
            checks++; if (bus.step_pulse !== (k == RD)) begin errors++; $display("FAIL ar_pulse_k%0d got %b exp %b", k, bus.step_pulse, (k == RD)); end
        end
        bus.run_sw = 0;
        cycle();
    endtask

    task automatic test_random();
        bus.bp_addr = 32'h10;
        for (int n = 0; n < 600; n++) begin
            if ($urandom_range(0, 15) == 0) bus.run_sw = !bus.run_sw;
            if ($urandom_range(0, 31) == 0) bus.bp_en = !bus.bp_en;
            bus.step_btn = ($urandom_range(0, 3) == 0);
            case ($urandom_range(0, 3))
                0, 1:    bus.pc = 32'h10;
                2:       bus.pc = 32'h14;
                default: bus.pc = 32'h8000_0010;
            endcase
            cycle();
            checks++; if (bus.step_pulse !== e_pulse) begin errors++; $display("FAIL rnd_pulse_n%0d got %b exp %b", n, bus.step_pulse, e_pulse); end
            checks++; if (bus.running !== (m_mode == M_RUN)) begin errors++; $display("FAIL rnd_running_n%0d got %b exp %b", n, bus.running, (m_mode == M_RUN)); end
            checks++; if (bus.halted !== (m_mode == M_HALT) || bus.bp_hit !== (m_mode == M_HALT)) begin errors++; $display("FAIL rnd_halt_n%0d got %b %b exp %b", n, bus.halted, bus.bp_hit, (m_mode == M_HALT)); end
            checks++; if (bus.step_count !== 16'(e_cnt)) begin errors++; $display("FAIL rnd_count_n%0d got %h exp %h", n, bus.step_count, 16'(e_cnt)); end
            checks++; if (bus4.step_count !== 4'(e_cnt)) begin errors++; $display("FAIL rnd_count4_n%0d got %h exp %h", n, bus4.step_count, 4'(e_cnt)); end
        end
        bus.run_sw = 0; bus.step_btn = 0; bus.bp_en = 0;
        cycle();
    endtask

    initial begin
        test_reset();
        test_single_step();
        test_free_run();
        test_breakpoint();
        test_simultaneous();
        test_wrap();
        test_async_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got running exp finished");
        $fatal(1, "timeout");
    end

endmodule
